// File: rtl/rs_pkg.sv
// Shared definitions for the RS(N,K) encoder over GF(2^8): widths, default code
// size, sequencer states and the generator coefficients used by the parity stages.
`timescale 1ns/1ps
`default_nettype none
package rs_pkg;

  localparam int SYM_W   = 8;
  localparam int RS_N    = 255;
  localparam int RS_K    = 239;
  localparam int RS_NPAR = RS_N - RS_K;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MSG  = 2'd1,
    PAR  = 2'd2
  } rs_state_e;

  // Field multiply, primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D).
  function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a,
                                              input logic [SYM_W-1:0] b);
    logic [SYM_W-1:0] p;
    logic [SYM_W-1:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < SYM_W; i++) begin
      if (b[i]) p = p ^ x;
      x = x[SYM_W-1] ? ((x << 1) ^ 8'h1D) : (x << 1);
    end
    return p;
  endfunction

  // g(x) = prod_{i=0}^{NPAR-1} (x - alpha^i); coefficient of x^i at bits [8i +: 8].
  function automatic logic [RS_NPAR*SYM_W-1:0] gen_poly();
    logic [SYM_W-1:0] g [RS_NPAR+1];
    logic [SYM_W-1:0] root;
    logic [RS_NPAR*SYM_W-1:0] packed_g;
    for (int j = 0; j <= RS_NPAR; j++) g[j] = '0;
    g[0] = 8'h01;
    root = 8'h01;
    for (int r = 0; r < RS_NPAR; r++) begin
      for (int j = RS_NPAR; j >= 1; j--) g[j] = g[j-1] ^ gf_mul(g[j], root);
      g[0] = gf_mul(g[0], root);
      root = gf_mul(root, 8'h02);
    end
    for (int j = 0; j < RS_NPAR; j++) packed_g[j*SYM_W +: SYM_W] = g[j];
    return packed_g;
  endfunction

  localparam logic [RS_NPAR*SYM_W-1:0] GEN_COEF = gen_poly();

endpackage
`default_nettype wire

// File: rtl/rs_enc_ctrl.sv
// Frame sequencer for the systematic RS encoder: passes K message symbols through,
// steers the external parity bank, then shifts out the NPAR parity symbols.
`timescale 1ns/1ps
`default_nettype none
module rs_enc_ctrl
  import rs_pkg::*;
#(
  parameter int N = RS_N,
  parameter int K = RS_K
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SYM_W-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_sop,
  output logic             in_ready,
  output logic [SYM_W-1:0] fb_sym,
  output logic             par_en,
  output logic             par_clr,
  input  logic [SYM_W-1:0] par_tail,
  output logic [SYM_W-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             sop_err
);

  localparam int         NPAR      = N - K;
  localparam logic [7:0] K_LAST    = 8'(K - 1);
  localparam logic [7:0] NPAR_LAST = 8'(NPAR - 1);

  rs_state_e        state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [SYM_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             sop_err_q, sop_err_d;
  logic             adv;
  logic             accept;

  always_comb begin
    adv         = !out_valid_q | out_ready;
    in_ready    = adv & (state_q != PAR) & !rst;
    accept      = in_valid & in_ready;
    par_en      = 1'b0;
    par_clr     = rst | (state_q == IDLE);
    fb_sym      = '0;
    sop_err_d   = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    if (adv) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_sop) begin
            par_en      = 1'b1;
            fb_sym      = in_data;
            out_valid_d = 1'b1;
            out_data_d  = in_data;
            cnt_d       = 8'd1;
            state_d     = MSG;
          end else begin
            sop_err_d = 1'b1;
          end
        end
      end
      MSG: begin
        if (accept) begin
          par_en      = 1'b1;
          out_valid_d = 1'b1;
          out_data_d  = in_data;
          // A restart clears the bank in the same step it loads, so the tail is ignored.
          if (in_sop) begin
            sop_err_d = 1'b1;
            par_clr   = 1'b1;
            fb_sym    = in_data;
            cnt_d     = 8'd1;
          end else begin
            fb_sym = in_data ^ par_tail;
            if (cnt_q == K_LAST) begin
              cnt_d   = 8'd0;
              state_d = PAR;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
      end
      PAR: begin
        if (adv && !rst) begin
          par_en      = 1'b1;
          out_valid_d = 1'b1;
          out_data_d  = par_tail;
          if (cnt_q == NPAR_LAST) begin
            out_last_d = 1'b1;
            cnt_d      = 8'd0;
            state_d    = IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      sop_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      sop_err_q   <= sop_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign sop_err   = sop_err_q;

endmodule
`default_nettype wire

// File: tb/tb_rs_enc_ctrl.sv
// Bench for rs_enc_ctrl: behavioural parity bank, long-division codeword model and scoreboard.
`timescale 1ns/1ps
`default_nettype none
module tb_rs_enc_ctrl;

  localparam int N  = 255;
  localparam int K  = 239;
  localparam int NP = N - K;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_sop = 1'b0;
  logic       in_ready;
  logic [7:0] fb_sym;
  logic       par_en;
  logic       par_clr;
  logic [7:0] par_tail;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready = 1'b1;
  logic       sop_err;

  rs_enc_ctrl #(.N(N), .K(K)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
    .in_ready(in_ready), .fb_sym(fb_sym), .par_en(par_en), .par_clr(par_clr),
    .par_tail(par_tail), .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .sop_err(sop_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_sop_err = 0;
  int rdy_mode = 0;   // 0 manual, 1 always ready, 2 random
  logic mon_en = 1'b0;

  logic [7:0] gen [NP+1];
  logic [7:0] bank [NP];
  logic [7:0] msg [K];
  logic [8:0] exp_q [$];
  logic [7:0] cap_d [$];
  int         cap_c [$];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
    end
    return p;
  endfunction

  task automatic init_gen();
    logic [7:0] root;
    for (int j = 0; j <= NP; j++) gen[j] = 8'h00;
    gen[0] = 8'h01;
    root = 8'h01;
    for (int r = 0; r < NP; r++) begin
      for (int j = NP; j >= 1; j--) gen[j] = gen[j-1] ^ gmul(gen[j], root);
      gen[0] = gmul(gen[0], root);
      root = gmul(root, 8'h02);
    end
  endtask

  // External parity bank: clear-and-load when both par_clr and par_en are set.
  assign par_tail = bank[NP-1];
  always @(posedge clk) begin
    if (par_en) begin
      bank[0] <= gmul(fb_sym, gen[0]);
      for (int i = 1; i < NP; i++)
        bank[i] <= (par_clr ? 8'h00 : bank[i-1]) ^ gmul(fb_sym, gen[i]);
    end else if (par_clr) begin
      for (int i = 0; i < NP; i++) bank[i] <= 8'h00;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out at cycle %0d", nm, cyc);
  endtask

  always @(negedge clk) begin
    if (sop_err) n_sop_err++;
    if (mon_en && out_valid && out_ready) begin
      cap_d.push_back(out_data);
      cap_c.push_back(cyc);
      if (exp_q.size() == 0) begin
        timeout("extra_beat");
      end else begin
        chk("beat", {23'd0, out_last, out_data}, {23'd0, exp_q.pop_front()});
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_mode == 1) out_ready = 1'b1;
    else if (rdy_mode == 2) out_ready = 1'($urandom_range(0, 1));
  end

  // Systematic codeword by polynomial long division of m(x)*x^NP by g(x).
  task automatic push_frame();
    logic [7:0] d [N];
    logic [7:0] coef;
    for (int i = 0; i < N; i++) d[i] = (i < K) ? msg[i] : 8'h00;
    for (int i = 0; i < K; i++) begin
      coef = d[i];
      for (int j = 1; j <= NP; j++) d[i+j] = d[i+j] ^ gmul(coef, gen[NP-j]);
    end
    for (int i = 0; i < K; i++) exp_q.push_back({1'b0, msg[i]});
    for (int j = 0; j < NP; j++) exp_q.push_back({(j == NP-1), d[K+j]});
  endtask

  task automatic send_sym(input logic [7:0] d, input logic sop);
    int t;
    if (rdy_mode == 2 && $urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_sop   = sop;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) timeout("in_ready_wait");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic send_frame(input int first, input int count);
    for (int i = first; i < first + count; i++) send_sym(msg[i], (i == first));
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) timeout(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < K; i++) msg[i] = 8'($urandom);
  endtask

  typedef struct {
    logic       rst, iv, sop;
    logic [7:0] d;
    logic       ordy;
    logic       e_rdy, e_ov, e_err, e_clr, e_en;
    logic [7:0] e_fb;
  } vec_t;

  vec_t tbl [11];

  initial begin : main
    logic [7:0] s;
    logic [7:0] a;
    logic [7:0] syn_or;
    int base;
    int t;
    int ev0;
    init_gen();

    //             rst   iv    sop   data   ordy  rdy   ov    err   clr   en    fb
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 8'hA7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA7};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                8'h3C ^ gmul(8'hA7, gen[NP-1])};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};

    repeat (3) @(posedge clk);
    for (int i = 0; i < 11; i++) begin
      @(posedge clk);
      #1;
      rst = tbl[i].rst; in_valid = tbl[i].iv; in_sop = tbl[i].sop;
      in_data = tbl[i].d; out_ready = tbl[i].ordy;
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          {19'd0, in_ready, out_valid, sop_err, par_clr, par_en, fb_sym},
          {19'd0, tbl[i].e_rdy, tbl[i].e_ov, tbl[i].e_err, tbl[i].e_clr, tbl[i].e_en, tbl[i].e_fb});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_sop = 1'b0; in_data = 8'h00;
    rdy_mode = 1;
    mon_en = 1'b1;

    // All-zero frame
    for (int i = 0; i < K; i++) msg[i] = 8'h00;
    push_frame();
    send_frame(0, K);
    drain("zero_frame");

    // Single 0x01 followed by zeros, checked by syndromes of the emitted codeword
    cap_d.delete(); cap_c.delete();
    msg[0] = 8'h01;
    push_frame();
    send_frame(0, K);
    drain("impulse_frame");
    chk("impulse_len", cap_d.size(), N);
    syn_or = 8'h00;
    a = 8'h01;
    for (int r = 0; r < NP; r++) begin
      s = 8'h00;
      for (int j = 0; j < cap_d.size(); j++) s = gmul(s, a) ^ cap_d[j];
      syn_or = syn_or | s;
      a = gmul(a, 8'h02);
    end
    chk("syndromes", syn_or, 8'h00);

    // Random messages, random backpressure and input gaps
    rdy_mode = 2;
    for (int f = 0; f < 3; f++) begin
      fill_rand();
      push_frame();
      send_frame(0, K);
    end
    drain("random_frames");

    // Restart on symbol 100
    ev0 = n_sop_err;
    fill_rand();
    for (int i = 0; i < 99; i++) exp_q.push_back({1'b0, msg[i]});
    send_frame(0, 99);
    fill_rand();
    push_frame();
    send_frame(0, K);
    drain("restart_frame");
    chk("restart_sop_err", n_sop_err - ev0, 1);

    // Reset during parity shift-out
    rdy_mode = 1;
    cap_d.delete(); cap_c.delete();
    fill_rand();
    push_frame();
    send_frame(0, K);
    t = 0;
    while (cap_d.size() < K + 5 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (cap_d.size() < K + 5) timeout("par5_wait");
    rst = 1'b1;
    mon_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
    rdy_mode = 2;
    fill_rand();
    push_frame();
    send_frame(0, K);
    drain("post_rst_frame");

    // Back-to-back frames at full rate
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    cap_d.delete(); cap_c.delete();
    for (int f = 0; f < 2; f++) begin
      fill_rand();
      push_frame();
      send_frame(0, K);
    end
    drain("b2b_frames");
    if (cap_c.size() >= N + 1) begin
      chk("b2b_throughput", cap_c[N-1] - cap_c[0], N - 1);
      chk("b2b_gap", cap_c[N] - cap_c[N-1], 1);
    end else begin
      timeout("b2b_beats");
    end
    chk("b2b_count", cap_d.size(), 2 * N);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
